// File: rtl/uart_boot_loader.sv
// uart_boot_loader: parses SYNC/LEN/ADDR/DATA/CSUM frames from the UART byte
// stream, writes 16-bit words into MU0 program memory and holds the core in
// reset until a frame with a good checksum has been loaded.
module uart_boot_loader #(
   parameter int unsigned CLK_FREQ    = 50000000,
   parameter int unsigned AW          = 12,
   parameter logic [7:0]  SYNC        = 8'hA5,
   parameter int unsigned TIMEOUT_CYC = CLK_FREQ / 50
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          rx_done,
   input  logic [7:0]    rx_data,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [15:0]   mem_wdata,
   output logic          cpu_rst_n,
   output logic          busy,
   output logic          load_ok,
   output logic          load_err
);

   localparam int unsigned TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam int unsigned CW = 9;

   typedef enum logic [2:0] {
      ST_IDLE, ST_LEN, ST_ADDR_H, ST_ADDR_L, ST_DATA_H, ST_DATA_L, ST_CSUM
   } state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   nwords_q, nwords_d;
   logic [CW-1:0]   idx_q, idx_d;
   logic [AW-1:0]   base_q, base_d;
   logic [7:0]      hi_q, hi_d;
   logic [7:0]      csum_q, csum_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic            mem_we_q, mem_we_d;
   logic [AW-1:0]   mem_addr_q, mem_addr_d;
   logic [15:0]     mem_wdata_q, mem_wdata_d;
   logic            cpu_rst_n_q, cpu_rst_n_d;
   logic            busy_q, busy_d;
   logic            load_ok_q, load_ok_d;
   logic            load_err_q, load_err_d;

   // Next-state and output logic for the frame parser and inter-byte timeout
   always_comb begin
      state_d     = state_q;
      nwords_d    = nwords_q;
      idx_d       = idx_q;
      base_d      = base_q;
      hi_d        = hi_q;
      csum_d      = csum_q;
      tmo_d       = tmo_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      cpu_rst_n_d = cpu_rst_n_q;
      load_ok_d   = 1'b0;
      load_err_d  = load_err_q;

      if (state_q == ST_IDLE) begin
         tmo_d = '0;
         if (rx_done && (rx_data == SYNC)) begin
            state_d     = ST_LEN;
            load_err_d  = 1'b0;
            cpu_rst_n_d = 1'b0;
            csum_d      = '0;
            idx_d       = '0;
         end
      end else if (rx_done) begin
         // A byte arriving on the terminal-count cycle takes priority.
         tmo_d = '0;
         case (state_q)
            ST_LEN: begin
               nwords_d = (rx_data == 8'h00) ? CW'(256) : CW'(rx_data);
               csum_d   = csum_q + rx_data;
               state_d  = ST_ADDR_H;
            end
            ST_ADDR_H: begin
               hi_d    = rx_data;
               csum_d  = csum_q + rx_data;
               state_d = ST_ADDR_L;
            end
            ST_ADDR_L: begin
               base_d  = AW'({hi_q, rx_data});
               csum_d  = csum_q + rx_data;
               state_d = ST_DATA_H;
            end
            ST_DATA_H: begin
               hi_d    = rx_data;
               csum_d  = csum_q + rx_data;
               state_d = ST_DATA_L;
            end
            ST_DATA_L: begin
               mem_we_d    = 1'b1;
               mem_addr_d  = base_q + AW'(idx_q);
               mem_wdata_d = {hi_q, rx_data};
               csum_d      = csum_q + rx_data;
               idx_d       = idx_q + CW'(1);
               state_d     = ((idx_q + CW'(1)) == nwords_q) ? ST_CSUM : ST_DATA_H;
            end
            ST_CSUM: begin
               if (rx_data == csum_q) begin
                  cpu_rst_n_d = 1'b1;
                  load_ok_d   = 1'b1;
               end else begin
                  load_err_d  = 1'b1;
               end
               state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
         load_err_d  = 1'b1;
         cpu_rst_n_d = 1'b0;
         tmo_d       = '0;
         state_d     = ST_IDLE;
      end else begin
         tmo_d = tmo_q + TW'(1);
      end

      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers; asynchronous reset discards any partial frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         nwords_q    <= '0;
         idx_q       <= '0;
         base_q      <= '0;
         hi_q        <= '0;
         csum_q      <= '0;
         tmo_q       <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         cpu_rst_n_q <= 1'b0;
         busy_q      <= 1'b0;
         load_ok_q   <= 1'b0;
         load_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         nwords_q    <= nwords_d;
         idx_q       <= idx_d;
         base_q      <= base_d;
         hi_q        <= hi_d;
         csum_q      <= csum_d;
         tmo_q       <= tmo_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         cpu_rst_n_q <= cpu_rst_n_d;
         busy_q      <= busy_d;
         load_ok_q   <= load_ok_d;
         load_err_q  <= load_err_d;
      end
   end

   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign cpu_rst_n = cpu_rst_n_q;
   assign busy      = busy_q;
   assign load_ok   = load_ok_q;
   assign load_err  = load_err_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Testbench for uart_boot_loader: frames are built from their field values,
// expected writes and status come from the frame definition, and a monitor
// records every memory write and load_ok pulse.
module tb_uart_boot_loader;

   localparam int unsigned AW  = 12;
   localparam int unsigned TMO = 100;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [15:0]   d;
   } wr_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          rx_done = 1'b0;
   logic [7:0]    rx_data = 8'h00;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [15:0]   mem_wdata;
   logic          cpu_rst_n;
   logic          busy;
   logic          load_ok;
   logic          load_err;

   wr_t        wr_q[$];
   wr_t        exp_q[$];
   logic [7:0] tx_q[$];
   int         ok_cnt = 0;
   int         n_chk  = 0;
   int         n_pass = 0;

   always #5 clk = ~clk;

   uart_boot_loader #(
      .CLK_FREQ(50000000), .AW(AW), .SYNC(8'hA5), .TIMEOUT_CYC(TMO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .rx_done(rx_done), .rx_data(rx_data),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .cpu_rst_n(cpu_rst_n), .busy(busy), .load_ok(load_ok), .load_err(load_err)
   );

   // Record writes and load_ok pulses mid-cycle
   always @(negedge clk) begin
      if (mem_we) wr_q.push_back('{a: mem_addr, d: mem_wdata});
      if (load_ok) ok_cnt++;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_mon();
      wr_q   = {};
      ok_cnt = 0;
   endtask

   // Drive tx_q, 0..max_gap idle cycles after each byte (0 = back-to-back)
   task automatic send_tx(input int max_gap);
      foreach (tx_q[i]) begin
         @(negedge clk);
         rx_done = 1'b1;
         rx_data = tx_q[i];
         repeat ($urandom_range(max_gap, 0)) begin
            @(negedge clk);
            rx_done = 1'b0;
            rx_data = 8'($urandom);
         end
      end
      @(negedge clk);
      rx_done = 1'b0;
      rx_data = 8'($urandom);
   endtask

   // Reference frame: bytes to send and the writes the frame must produce
   task automatic build_frame(input logic [7:0] len_b, input logic [15:0] addr,
                              input logic [15:0] words[$], input logic [7:0] csum_delta);
      int n;
      logic [7:0] s;
      n = (len_b == 8'h00) ? 256 : int'(len_b);
      tx_q  = {};
      exp_q = {};
      tx_q.push_back(8'hA5);
      tx_q.push_back(len_b);
      tx_q.push_back(addr[15:8]);
      tx_q.push_back(addr[7:0]);
      s = 8'(len_b + addr[15:8] + addr[7:0]);
      for (int i = 0; i < n; i++) begin
         tx_q.push_back(words[i][15:8]);
         tx_q.push_back(words[i][7:0]);
         s = 8'(s + words[i][15:8] + words[i][7:0]);
         exp_q.push_back('{a: AW'((int'(addr[AW-1:0]) + i) % 4096), d: words[i]});
      end
      tx_q.push_back(8'(s + csum_delta));
   endtask

   // The documented example frame with a chosen final checksum byte
   task automatic plan_frame(input logic [7:0] csum);
      tx_q  = {8'hA5, 8'h02, 8'h00, 8'h10, 8'h12, 8'h34, 8'hAB, 8'hCD, csum};
      exp_q = {};
      exp_q.push_back('{a: 12'h010, d: 16'h1234});
      exp_q.push_back('{a: 12'h011, d: 16'hABCD});
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick(3);
      n_chk++;
      if ({mem_we, mem_addr, mem_wdata, cpu_rst_n, busy, load_ok, load_err} !== '0)
         $display("FAIL reset_outputs: got we=%b addr=%h wd=%h crn=%b busy=%b ok=%b err=%b want all 0",
                  mem_we, mem_addr, mem_wdata, cpu_rst_n, busy, load_ok, load_err);
      else n_pass++;
      rst_n = 1'b1;
      tick(2);
      n_chk++;
      if ({cpu_rst_n, busy, load_err} !== 3'b000)
         $display("FAIL reset_release: got crn/busy/err=%b want 000", {cpu_rst_n, busy, load_err});
      else n_pass++;
   endtask

   task automatic test_good_frame();
      clear_mon();
      plan_frame(8'hD0);
      send_tx(2);
      tick(3);
      n_chk++;
      if (wr_q.size() != exp_q.size()) $display("FAIL good_nwr: got %0d want %0d", wr_q.size(), exp_q.size());
      else n_pass++;
      for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
         n_chk++;
         if (wr_q[i] !== exp_q[i])
            $display("FAIL good_wr%0d: got %h/%h want %h/%h", i, wr_q[i].a, wr_q[i].d, exp_q[i].a, exp_q[i].d);
         else n_pass++;
      end
      n_chk++;
      if (ok_cnt != 1) $display("FAIL good_load_ok: got %0d pulses want 1", ok_cnt);
      else n_pass++;
      n_chk++;
      if ({cpu_rst_n, load_err, busy} !== 3'b100)
         $display("FAIL good_status: got crn/err/busy=%b want 100", {cpu_rst_n, load_err, busy});
      else n_pass++;
   endtask

   task automatic test_bad_csum();
      clear_mon();
      plan_frame(8'hD1);
      send_tx(1);
      tick(3);
      n_chk++;
      if (wr_q.size() != exp_q.size()) $display("FAIL bad_nwr: got %0d want %0d", wr_q.size(), exp_q.size());
      else n_pass++;
      for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
         n_chk++;
         if (wr_q[i] !== exp_q[i])
            $display("FAIL bad_wr%0d: got %h/%h want %h/%h", i, wr_q[i].a, wr_q[i].d, exp_q[i].a, exp_q[i].d);
         else n_pass++;
      end
      n_chk++;
      if (ok_cnt != 0) $display("FAIL bad_load_ok: got %0d pulses want 0", ok_cnt);
      else n_pass++;
      n_chk++;
      if ({cpu_rst_n, load_err, busy} !== 3'b010)
         $display("FAIL bad_status: got crn/err/busy=%b want 010", {cpu_rst_n, load_err, busy});
      else n_pass++;
      tx_q = {8'hA5};
      send_tx(0);
      tick(1);
      n_chk++;
      if ({cpu_rst_n, load_err, busy} !== 3'b001)
         $display("FAIL sync_clears_err: got crn/err/busy=%b want 001", {cpu_rst_n, load_err, busy});
      else n_pass++;
      tick(TMO + 10);
      n_chk++;
      if ({load_err, busy} !== 2'b10)
         $display("FAIL bad_drain: got err/busy=%b want 10", {load_err, busy});
      else n_pass++;
   endtask

   task automatic test_idle_garbage();
      logic [7:0] junk[3];
      junk = '{8'h00, 8'hFF, 8'h5A};
      clear_mon();
      foreach (junk[i]) begin
         @(negedge clk);
         rx_done = 1'b1;
         rx_data = junk[i];
         @(negedge clk);
         rx_done = 1'b0;
         n_chk++;
         if (busy !== 1'b0 || wr_q.size() != 0)
            $display("FAIL garbage_idle%0d: got busy=%b nwr=%0d want busy=0 nwr=0", i, busy, wr_q.size());
         else n_pass++;
      end
      plan_frame(8'hD0);
      send_tx(0);
      tick(3);
      n_chk++;
      if (wr_q.size() != exp_q.size()) $display("FAIL garbage_nwr: got %0d want %0d", wr_q.size(), exp_q.size());
      else n_pass++;
      for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
         n_chk++;
         if (wr_q[i] !== exp_q[i])
            $display("FAIL garbage_wr%0d: got %h/%h want %h/%h", i, wr_q[i].a, wr_q[i].d, exp_q[i].a, exp_q[i].d);
         else n_pass++;
      end
      n_chk++;
      if (ok_cnt != 1 || {cpu_rst_n, load_err, busy} !== 3'b100)
         $display("FAIL garbage_status: got ok=%0d crn/err/busy=%b want ok=1 100", ok_cnt, {cpu_rst_n, load_err, busy});
      else n_pass++;
   endtask

   task automatic test_timeout();
      clear_mon();
      tx_q = {8'hA5, 8'h01, 8'h00};
      send_tx(0);
      tick(TMO - 6);
      n_chk++;
      if ({busy, load_err, cpu_rst_n} !== 3'b100)
         $display("FAIL tmo_before: got busy/err/crn=%b want 100", {busy, load_err, cpu_rst_n});
      else n_pass++;
      tick(10);
      n_chk++;
      if ({busy, load_err, cpu_rst_n} !== 3'b010)
         $display("FAIL tmo_after: got busy/err/crn=%b want 010", {busy, load_err, cpu_rst_n});
      else n_pass++;
      n_chk++;
      if (wr_q.size() != 0 || ok_cnt != 0)
         $display("FAIL tmo_nowrite: got nwr=%0d ok=%0d want 0 0", wr_q.size(), ok_cnt);
      else n_pass++;
   endtask

   task automatic test_wrap();
      logic [15:0] w[$];
      clear_mon();
      w = {16'h1111, 16'h2222};
      build_frame(8'h02, 16'h0FFF, w, 8'h00);
      send_tx(1);
      tick(3);
      n_chk++;
      if (wr_q.size() != 2) $display("FAIL wrap_nwr: got %0d want 2", wr_q.size());
      else n_pass++;
      n_chk++;
      if (wr_q.size() == 2 && (wr_q[0] !== wr_t'({12'hFFF, 16'h1111}) || wr_q[1] !== wr_t'({12'h000, 16'h2222})))
         $display("FAIL wrap_addr: got %h/%h %h/%h want fff/1111 000/2222",
                  wr_q[0].a, wr_q[0].d, wr_q[1].a, wr_q[1].d);
      else if (wr_q.size() == 2) n_pass++;
      n_chk++;
      if (ok_cnt != 1 || {cpu_rst_n, load_err, busy} !== 3'b100)
         $display("FAIL wrap_status: got ok=%0d crn/err/busy=%b want ok=1 100", ok_cnt, {cpu_rst_n, load_err, busy});
      else n_pass++;
   endtask

   task automatic test_len0();
      logic [15:0] w[$];
      logic [7:0]  csum_b;
      int          bad;
      clear_mon();
      for (int i = 0; i < 256; i++) w.push_back(16'($urandom));
      build_frame(8'h00, 16'($urandom), w, 8'h00);
      csum_b = tx_q.pop_back();
      send_tx(1);
      tick(2);
      n_chk++;
      if (wr_q.size() != 256 || busy !== 1'b1 || ok_cnt != 0)
         $display("FAIL len0_before_csum: got nwr=%0d busy=%b ok=%0d want 256 1 0", wr_q.size(), busy, ok_cnt);
      else n_pass++;
      bad = 0;
      for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
         if (wr_q[i] !== exp_q[i]) bad++;
      n_chk++;
      if (bad != 0) $display("FAIL len0_data: got %0d wrong writes want 0", bad);
      else n_pass++;
      tx_q = {csum_b};
      send_tx(0);
      tick(2);
      n_chk++;
      if (ok_cnt != 1 || wr_q.size() != 256 || {cpu_rst_n, load_err, busy} !== 3'b100)
         $display("FAIL len0_status: got ok=%0d nwr=%0d crn/err/busy=%b want 1 256 100",
                  ok_cnt, wr_q.size(), {cpu_rst_n, load_err, busy});
      else n_pass++;
   endtask

   // Random frames; max_gap 0 gives fully back-to-back byte pulses
   task automatic test_random(input int nframes, input int max_gap);
      logic [15:0] w[$];
      logic [7:0]  len_b, delta;
      for (int f = 0; f < nframes; f++) begin
         clear_mon();
         w = {};
         len_b = 8'($urandom_range(6, 1));
         for (int i = 0; i < int'(len_b); i++) w.push_back(16'($urandom));
         delta = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
         build_frame(len_b, 16'($urandom), w, delta);
         send_tx(max_gap);
         tick(3);
         n_chk++;
         if (wr_q.size() != exp_q.size())
            $display("FAIL rnd%0d_nwr: got %0d want %0d", f, wr_q.size(), exp_q.size());
         else n_pass++;
         for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
            n_chk++;
            if (wr_q[i] !== exp_q[i])
               $display("FAIL rnd%0d_wr%0d: got %h/%h want %h/%h", f, i,
                        wr_q[i].a, wr_q[i].d, exp_q[i].a, exp_q[i].d);
            else n_pass++;
         end
         n_chk++;
         if (ok_cnt != ((delta == 8'h00) ? 1 : 0) ||
             {cpu_rst_n, load_err, busy} !== {delta == 8'h00, delta != 8'h00, 1'b0})
            $display("FAIL rnd%0d_status: got ok=%0d crn/err/busy=%b want good=%0d",
                     f, ok_cnt, {cpu_rst_n, load_err, busy}, delta == 8'h00);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid_frame();
      clear_mon();
      tx_q = {8'hA5, 8'h02, 8'h00, 8'h10, 8'h12};
      send_tx(0);
      @(negedge clk);
      rx_done = 1'b1;
      rx_data = 8'h34;
      @(posedge clk);
      #1;
      n_chk++;
      if (mem_we !== 1'b1 || busy !== 1'b1)
         $display("FAIL rstmid_inflight: got we=%b busy=%b want 1 1", mem_we, busy);
      else n_pass++;
      rx_done = 1'b0;
      rst_n   = 1'b0;
      #1;
      n_chk++;
      if ({mem_we, mem_addr, mem_wdata, cpu_rst_n, busy, load_ok, load_err} !== '0)
         $display("FAIL rstmid_outputs: got we=%b addr=%h wd=%h crn=%b busy=%b ok=%b err=%b want all 0",
                  mem_we, mem_addr, mem_wdata, cpu_rst_n, busy, load_ok, load_err);
      else n_pass++;
      tick(3);
      n_chk++;
      if (wr_q.size() != 0) $display("FAIL rstmid_nowrite: got %0d writes want 0", wr_q.size());
      else n_pass++;
      rst_n = 1'b1;
      tick(2);
      plan_frame(8'hD0);
      send_tx(1);
      tick(3);
      n_chk++;
      if (wr_q.size() != 2 || (wr_q.size() == 2 && (wr_q[0] !== exp_q[0] || wr_q[1] !== exp_q[1])))
         $display("FAIL rstmid_reload: got nwr=%0d want 2 writes 010/1234 011/abcd", wr_q.size());
      else n_pass++;
      n_chk++;
      if (ok_cnt != 1 || {cpu_rst_n, load_err, busy} !== 3'b100)
         $display("FAIL rstmid_status: got ok=%0d crn/err/busy=%b want ok=1 100", ok_cnt, {cpu_rst_n, load_err, busy});
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_bad_csum();
      test_idle_garbage();
      test_timeout();
      test_wrap();
      test_len0();
      test_random(12, 3);
      test_random(4, 0);
      test_reset_mid_frame();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
